// File: rtl/ex_issue_ctrl_pkg.sv
// ex_issue_ctrl_pkg: shared ALU control codes, datapath defaults and EX-stage FSM states.
package ex_issue_ctrl_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 5;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_ADD    = 5'd0;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_SUB    = 5'd1;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_AND    = 5'd2;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_OR     = 5'd3;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_XOR    = 5'd4;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_SLL    = 5'd5;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_SRL    = 5'd6;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_SRA    = 5'd7;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_SLT    = 5'd8;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_SLTU   = 5'd9;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_BEQ    = 5'd10;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_BNE    = 5'd11;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_BLT    = 5'd12;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_BGE    = 5'd13;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_BLTU   = 5'd14;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_BGEU   = 5'd15;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_JAL    = 5'd16;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_MUL    = 5'd17;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_MULH   = 5'd18;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_MULHSU = 5'd19;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_MULHU  = 5'd20;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_DIV    = 5'd21;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_DIVU   = 5'd22;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_REM    = 5'd23;
  localparam logic [CTRL_W_DEF-1:0] ALUCTRL_REMU   = 5'd24;

  typedef enum logic [1:0] {RUN, MD_WAIT, MD_DONE} ex_state_e;

  function automatic logic is_md(input logic [CTRL_W_DEF-1:0] c);
    return (c >= ALUCTRL_MUL) && (c <= ALUCTRL_REMU);
  endfunction

  function automatic logic is_br(input logic [CTRL_W_DEF-1:0] c);
    return (c >= ALUCTRL_BEQ) && (c <= ALUCTRL_JAL);
  endfunction
endpackage

// File: rtl/ex_issue_ctrl_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register that holds its contents while en_i is low.
module ex_mem_reg
  import ex_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [4:0]        rd_i,
  input  logic              regwrite_i,
  input  logic              taken_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] result_o,
  output logic [4:0]        rd_o,
  output logic              regwrite_o,
  output logic              taken_o
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_o    <= 1'b0;
      result_o   <= '0;
      rd_o       <= '0;
      regwrite_o <= 1'b0;
      taken_o    <= 1'b0;
    end else if (en_i) begin
      valid_o    <= valid_i;
      result_o   <= result_i;
      rd_o       <= rd_i;
      regwrite_o <= regwrite_i;
      taken_o    <= taken_i;
    end
endmodule

// File: rtl/ex_issue_ctrl.sv
// ex_issue_ctrl: ID/EX register and issue FSM driving the ALU, stalling ID across
// multi-cycle mult/div ops and feeding results into the EX/MEM register.
module ex_issue_ctrl
  import ex_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_alu_ctrl,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc,
  input  logic              id_pcsrc,
  input  logic              id_immsrc,
  input  logic [4:0]        id_rd,
  input  logic              id_regwrite,
  input  logic              flush,
  input  logic              mem_stall,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] pc_out,
  output logic              alu_pcsrc,
  output logic              alu_immsrc,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_is_zero,
  input  logic              alu_ready,
  output logic              ex_stall,
  output logic              branch_taken,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic [4:0]        mem_rd,
  output logic              mem_regwrite
);
  ex_state_e         state_q, state_d;
  logic              v_q, v_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [CTRL_W-1:0] ctrl_q;
  logic [4:0]        rd_q;
  logic              regwrite_q;
  logic              md_op, kill, ex_v, load, run, done, wr_v;

  assign run      = state_q == RUN;
  assign done     = state_q == MD_DONE;
  assign md_op    = is_md(ctrl_q);
  assign kill     = flush & run;
  assign ex_v     = v_q & ~kill;
  assign ex_stall = ~run | mem_stall | (run & v_q & md_op);
  assign load     = ~ex_stall;
  // Outside a live op the ALU sees ADD so a stale mult/div code can never start it.
  assign alu_ctrl = (v_q & ~done) ? ctrl_q : CTRL_W'(ALUCTRL_ADD);

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    hold_d  = hold_q;
    case (state_q)
      RUN: begin
        v_d     = kill ? 1'b0 : (load ? id_valid : v_q);
        state_d = (v_q & md_op & ~flush) ? MD_WAIT : RUN;
      end
      MD_WAIT: if (alu_ready) begin
        hold_d  = alu_result;
        state_d = MD_DONE;
      end
      MD_DONE: if (!mem_stall) begin
        v_d     = 1'b0;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= RUN;
      v_q        <= 1'b0;
      hold_q     <= '0;
      ctrl_q     <= CTRL_W'(ALUCTRL_ADD);
      rdata1     <= '0;
      rdata2     <= '0;
      imm        <= '0;
      pc_out     <= '0;
      alu_pcsrc  <= 1'b0;
      alu_immsrc <= 1'b0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      hold_q  <= hold_d;
      if (load && id_valid) begin
        ctrl_q     <= id_alu_ctrl;
        rdata1     <= id_rdata1;
        rdata2     <= id_rdata2;
        imm        <= id_imm;
        pc_out     <= id_pc;
        alu_pcsrc  <= id_pcsrc;
        alu_immsrc <= id_immsrc;
        rd_q       <= id_rd;
        regwrite_q <= id_regwrite;
      end
    end

  assign wr_v = done | (run & ex_v & ~md_op);

  ex_mem_reg #(.DATA_W(DATA_W)) u_ex_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (~mem_stall),
    .valid_i   (wr_v),
    .result_i  (done ? hold_q : alu_result),
    .rd_i      (rd_q),
    .regwrite_i(wr_v & regwrite_q),
    .taken_i   (run & ex_v & is_br(ctrl_q) & alu_is_zero),
    .valid_o   (mem_valid),
    .result_o  (mem_result),
    .rd_o      (mem_rd),
    .regwrite_o(mem_regwrite),
    .taken_o   (branch_taken)
  );
endmodule

// File: tb/tb_ex_issue_ctrl.sv
// tb_ex_issue_ctrl: scoreboard bench for ex_issue_ctrl with a behavioural ALU whose
// mult/div raises alu_ready in cycle 33 after the ID/EX load edge.
module tb_ex_issue_ctrl;
  import ex_issue_ctrl_pkg::*;
  localparam int LAT = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_pcsrc, id_immsrc, id_regwrite, flush, mem_stall;
  logic [4:0]  id_alu_ctrl, id_rd;
  logic [31:0] id_rdata1, id_rdata2, id_imm, id_pc;
  logic [4:0]  alu_ctrl, mem_rd;
  logic [31:0] rdata1, rdata2, imm, pc_out, alu_result, mem_result;
  logic        alu_pcsrc, alu_immsrc, alu_is_zero, alu_ready;
  logic        ex_stall, branch_taken, mem_valid, mem_regwrite;

  typedef struct {logic [31:0] res; logic [4:0] rd; logic rw; logic br;} exp_t;
  exp_t sb[$];
  exp_t e;
  int total = 0, bad = 0, cyc = 0, pops = 0, last_pop = -10, consec = 0, md_starts = 0;

  always #5 clk = ~clk;

  ex_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_ctrl(id_alu_ctrl),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc(id_pc),
    .id_pcsrc(id_pcsrc), .id_immsrc(id_immsrc), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .flush(flush), .mem_stall(mem_stall), .alu_ctrl(alu_ctrl), .rdata1(rdata1),
    .rdata2(rdata2), .imm(imm), .pc_out(pc_out), .alu_pcsrc(alu_pcsrc),
    .alu_immsrc(alu_immsrc), .alu_result(alu_result), .alu_is_zero(alu_is_zero),
    .alu_ready(alu_ready), .ex_stall(ex_stall), .branch_taken(branch_taken),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite)
  );

  // Behavioural ALU: combinational single-cycle ops, fixed-latency mult/div.
  logic        busy;
  int          cnt;
  logic [4:0]  md_ctrl;
  logic [31:0] opa, opb, sres, mres;

  always_comb begin
    opa = alu_pcsrc ? pc_out : rdata1;
    opb = alu_immsrc ? imm : rdata2;
    case (alu_ctrl)
      ALUCTRL_ADD, ALUCTRL_JAL: sres = opa + opb;
      ALUCTRL_AND:  sres = opa & opb;
      ALUCTRL_OR:   sres = opa | opb;
      ALUCTRL_XOR:  sres = opa ^ opb;
      ALUCTRL_SLL:  sres = opa << opb[4:0];
      ALUCTRL_SRL:  sres = opa >> opb[4:0];
      ALUCTRL_SRA:  sres = $signed(opa) >>> opb[4:0];
      ALUCTRL_SLT:  sres = {31'b0, $signed(opa) < $signed(opb)};
      ALUCTRL_SLTU: sres = {31'b0, opa < opb};
      default:      sres = opa - opb;
    endcase
    case (md_ctrl)
      ALUCTRL_MUL:  mres = rdata1 * rdata2;
      ALUCTRL_DIVU: mres = (rdata2 == 0) ? 32'hFFFF_FFFF : rdata1 / rdata2;
      ALUCTRL_REM:  mres = (rdata2 == 0) ? rdata1 : 32'($signed(rdata1) % $signed(rdata2));
      default:      mres = 32'd0;
    endcase
    alu_ready   = busy && (cnt == LAT);
    alu_result  = alu_ready ? mres : sres;
    alu_is_zero = (alu_result == 32'd0);
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0; cnt <= 0; md_ctrl <= 5'd0;
    end else if (busy) begin
      cnt <= cnt + 1;
      if (cnt == LAT) busy <= 1'b0;
    end else if (alu_ctrl >= ALUCTRL_MUL && alu_ctrl <= ALUCTRL_REMU) begin
      busy <= 1'b1; cnt <= 1; md_ctrl <= alu_ctrl; md_starts <= md_starts + 1;
    end

  // Scoreboard monitor: a result is consumed when mem_valid is seen with MEM accepting.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst_n) begin
      total++;
      if (!mem_valid && (mem_regwrite || branch_taken)) begin
        bad++;
        $display("FAIL idle_flags: got regwrite=%0b taken=%0b with mem_valid=0, want 0 0", mem_regwrite, branch_taken);
      end
      if (mem_valid && !mem_stall) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got mem_valid=1 result=%0d rd=%0d, want no result", mem_result, mem_rd);
        end else begin
          e = sb.pop_front();
          if (mem_result !== e.res || mem_rd !== e.rd || mem_regwrite !== e.rw || branch_taken !== e.br) begin
            bad++;
            $display("FAIL sb_result: got res=%0d rd=%0d rw=%0b br=%0b, want res=%0d rd=%0d rw=%0b br=%0b",
                     mem_result, mem_rd, mem_regwrite, branch_taken, e.res, e.rd, e.rw, e.br);
          end
          pops++;
          consec = (cyc == last_pop + 1) ? consec + 1 : 1;
          last_pop = cyc;
        end
      end
    end
  end

  task automatic issue(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic isrc, input logic [4:0] rd, input logic rw);
    logic ok = 1'b0;
    id_alu_ctrl = c; id_rdata1 = a; id_rdata2 = b; id_imm = im; id_immsrc = isrc;
    id_rd = rd; id_regwrite = rw; id_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!ex_stall) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL issue_timeout: got ex_stall=1 for 200 cycles, want 0");
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; id_valid = 1'b0; id_alu_ctrl = 5'd0; id_rdata1 = 0; id_rdata2 = 0;
    id_imm = 0; id_pc = 0; id_pcsrc = 1'b0; id_immsrc = 1'b0; id_rd = 5'd0;
    id_regwrite = 1'b0; flush = 1'b0; mem_stall = 1'b0;
    repeat (2) @(negedge clk);
    total += 5;
    if (mem_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_valid: got %0b want 0", mem_valid); end
    if (ex_stall !== 1'b0) begin bad++; $display("FAIL rst_ex_stall: got %0b want 0", ex_stall); end
    if (alu_ctrl !== ALUCTRL_ADD) begin bad++; $display("FAIL rst_alu_ctrl: got %0d want %0d", alu_ctrl, ALUCTRL_ADD); end
    if (branch_taken !== 1'b0) begin bad++; $display("FAIL rst_branch: got %0b want 0", branch_taken); end
    if ({mem_result, rdata1, pc_out, mem_rd, mem_regwrite} !== '0) begin
      bad++; $display("FAIL rst_data: got result=%0h rdata1=%0h pc=%0h want all 0", mem_result, rdata1, pc_out);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_add;
    logic stall_seen = 1'b0;
    sb.push_back('{32'd12, 5'd3, 1'b1, 1'b0});
    issue(ALUCTRL_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3, 1'b1);
    id_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      stall_seen |= ex_stall;
      if (i == 0) begin
        total++;
        if (mem_valid !== 1'b0) begin bad++; $display("FAIL add_early: got mem_valid=%0b want 0", mem_valid); end
      end
      if (i == 1) begin
        total++;
        if (mem_valid !== 1'b1 || mem_result !== 32'd12) begin
          bad++; $display("FAIL add_result: got valid=%0b result=%0d want 1 12", mem_valid, mem_result);
        end
      end
      if (i == 2) begin
        total++;
        if (mem_valid !== 1'b0) begin bad++; $display("FAIL add_pulse: got mem_valid=%0b want 0", mem_valid); end
      end
      @(posedge clk); #1;
    end
    total++;
    if (stall_seen !== 1'b0) begin bad++; $display("FAIL add_stall: got ex_stall seen=%0b want 0", stall_seen); end
  endtask

  task automatic test_mem_stall;
    sb.push_back('{32'd9, 5'd4, 1'b1, 1'b0});
    issue(ALUCTRL_ADD, 32'd4, 32'd5, 32'd0, 1'b0, 5'd4, 1'b1);
    id_valid = 1'b0; mem_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (ex_stall !== 1'b1 || mem_valid !== 1'b0) begin
        bad++; $display("FAIL mstall_hold: got ex_stall=%0b mem_valid=%0b want 1 0", ex_stall, mem_valid);
      end
      @(posedge clk); #1;
    end
    mem_stall = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (mem_valid !== 1'b1 || mem_result !== 32'd9) begin
      bad++; $display("FAIL mstall_result: got valid=%0b result=%0d want 1 9", mem_valid, mem_result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    int   md0 = md_starts, stall_n = 0, pulses = 0;
    logic rdy_seen = 1'b0, ctrl_bad = 1'b0, exited = 1'b0;
    sb.push_back('{32'd42, 5'd5, 1'b1, 1'b0});
    issue(ALUCTRL_MUL, 32'd6, 32'd7, 32'd0, 1'b0, 5'd5, 1'b1);
    id_valid = 1'b0;
    for (int i = 0; i < 100 && !exited; i++) begin
      @(negedge clk);
      if (!ex_stall) exited = 1'b1;
      else begin
        stall_n++;
        if (!rdy_seen && alu_ctrl !== ALUCTRL_MUL) ctrl_bad = 1'b1;
        if (alu_ready) rdy_seen = 1'b1;
        if (mem_valid) pulses++;
        @(posedge clk); #1;
      end
    end
    total += 4;
    if (!exited || stall_n != LAT + 2) begin bad++; $display("FAIL mul_stall_len: got %0d stall cycles want %0d", stall_n, LAT + 2); end
    if (rdy_seen !== 1'b1 || ctrl_bad !== 1'b0) begin
      bad++; $display("FAIL mul_ctrl_hold: got ready_seen=%0b ctrl_changed=%0b want 1 0", rdy_seen, ctrl_bad);
    end
    if (mem_valid !== 1'b1 || mem_result !== 32'd42) begin
      bad++; $display("FAIL mul_result: got valid=%0b result=%0d want 1 42", mem_valid, mem_result);
    end
    if (md_starts - md0 != 1) begin bad++; $display("FAIL mul_starts: got %0d mult/div starts want 1", md_starts - md0); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (mem_valid) pulses++;
    end
    total += 2;
    if (pulses != 0) begin bad++; $display("FAIL mul_pulses: got %0d extra mem_valid cycles want 0", pulses); end
    if (md_starts - md0 != 1) begin bad++; $display("FAIL mul_restart: got %0d mult/div starts want 1", md_starts - md0); end
    @(posedge clk); #1;
  endtask

  task automatic test_divu_stall;
    logic rdy = 1'b0;
    sb.push_back('{32'd14, 5'd6, 1'b1, 1'b0});
    issue(ALUCTRL_DIVU, 32'd100, 32'd7, 32'd0, 1'b0, 5'd6, 1'b1);
    id_valid = 1'b0;
    for (int i = 0; i < 100 && !rdy; i++) begin
      @(negedge clk);
      if (alu_ready) rdy = 1'b1;
      else begin @(posedge clk); #1; end
    end
    total++;
    if (!rdy) begin bad++; $display("FAIL divu_ready: got no alu_ready in 100 cycles want ready"); end
    @(posedge clk); #1 mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (mem_valid !== 1'b0 || ex_stall !== 1'b1) begin
        bad++; $display("FAIL divu_hold: got mem_valid=%0b ex_stall=%0b want 0 1", mem_valid, ex_stall);
      end
      @(posedge clk); #1;
    end
    mem_stall = 1'b0;
    @(negedge clk);
    total++;
    if (mem_valid !== 1'b0) begin bad++; $display("FAIL divu_early: got mem_valid=%0b want 0", mem_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (mem_valid !== 1'b1 || mem_result !== 32'd14) begin
      bad++; $display("FAIL divu_result: got valid=%0b result=%0d want 1 14", mem_valid, mem_result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_branch_flush;
    sb.push_back('{32'd0, 5'd0, 1'b0, 1'b1});
    issue(ALUCTRL_BEQ, 32'd3, 32'd3, 32'd0, 1'b0, 5'd0, 1'b0);
    issue(ALUCTRL_ADD, 32'd9, 32'd9, 32'd0, 1'b0, 5'd7, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    total++;
    if (branch_taken !== 1'b1 || mem_valid !== 1'b1) begin
      bad++; $display("FAIL beq_taken: got taken=%0b valid=%0b want 1 1", branch_taken, mem_valid);
    end
    @(posedge clk); #1;
    flush = 1'b0; id_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (mem_valid !== 1'b0 || branch_taken !== 1'b0) begin
        bad++; $display("FAIL flush_kill: got valid=%0b taken=%0b want 0 0", mem_valid, branch_taken);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid;
    issue(ALUCTRL_REM, 32'd50, 32'd7, 32'd0, 1'b0, 5'd8, 1'b1);
    id_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total += 3;
    if (ex_stall !== 1'b0 || mem_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_ctrl: got ex_stall=%0b mem_valid=%0b want 0 0", ex_stall, mem_valid);
    end
    if (alu_ctrl !== ALUCTRL_ADD) begin bad++; $display("FAIL rstmid_alu: got %0d want %0d", alu_ctrl, ALUCTRL_ADD); end
    if ({mem_result, rdata1, rdata2} !== '0) begin
      bad++; $display("FAIL rstmid_data: got result=%0h rdata1=%0h rdata2=%0h want 0", mem_result, rdata1, rdata2);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    sb.push_back('{32'd2, 5'd9, 1'b1, 1'b0});
    issue(ALUCTRL_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd9, 1'b1);
    id_valid = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (mem_valid !== 1'b1 || mem_result !== 32'd2) begin
      bad++; $display("FAIL rstmid_add: got valid=%0b result=%0d want 1 2", mem_valid, mem_result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int p0 = pops;
    sb.push_back('{32'd30, 5'd1, 1'b1, 1'b0});
    sb.push_back('{32'd42, 5'd2, 1'b1, 1'b0});
    sb.push_back('{32'hFF, 5'd3, 1'b1, 1'b0});
    issue(ALUCTRL_ADD, 32'd10, 32'd99, 32'd20, 1'b1, 5'd1, 1'b1);
    issue(ALUCTRL_SUB, 32'd50, 32'd8, 32'd0, 1'b0, 5'd2, 1'b1);
    issue(ALUCTRL_XOR, 32'hF0, 32'h0F, 32'd0, 1'b0, 5'd3, 1'b1);
    id_valid = 1'b0; id_immsrc = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (pops - p0 != 3 || consec != 3) begin
      bad++; $display("FAIL b2b_consecutive: got %0d results, run of %0d want 3 3", pops - p0, consec);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_add;
    test_mem_stall;
    test_mul;
    test_divu_stall;
    test_branch_flush;
    test_reset_mid;
    test_back_to_back;
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d pending results want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
